control_unit_pipe: RTL and testbench
====================================

// Module: control_unit_pipe
// PURPOSE
//  Registered, handshaked RV32I decode stage: exact-match opcode decode into the core's control bundle, held in a
//  1-entry output register with valid/ready flow control. Adds illegal-opcode detection, a tag passthrough, pipeline
//  flush, and a FENCE drain state machine that stalls issue until the memory system reports idle.
//  Sits between instruction fetch and the execute/hazard stage.
// PARAMETERS
//  INSTR_W         32   instruction width (opcode = in_instr[6:0], funct7 = in_instr[31:25])
//  TAG_W           4    width of the sideband tag carried with each instruction
//  FENCE_MAX_WAIT  255  drain cycles before fence_timeout is raised; counter width = $clog2(FENCE_MAX_WAIT+1)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst_n          in   1        reset, asynchronous assert, active-low
//  in_valid       in   1        in_instr/in_tag valid
//  in_ready       out  1        stage accepts this cycle
//  in_instr       in   INSTR_W  instruction word
//  in_tag         in   TAG_W    sideband tag (e.g. PC slot)
//  out_valid      out  1        control bundle valid
//  out_ready      in   1        downstream consumes this cycle
//  out_tag        out  TAG_W    tag of the held instruction
//  MemtoReg, RegWrite, MemWrite, MemRead, branch, ALUSrc, jump, Jalr, Lui, Auipc, Fence, CSRR
//                 out  1 each   registered control bits
//  illegal        out  1        opcode not in the decode table
//  mul_div        out  1        M-extension op (see CONFIGURATION)
//  flush          in   1        synchronous pipeline flush
//  mem_idle       in   1        memory system has no outstanding transactions
//  fence_timeout  out  1        sticky: a drain hit FENCE_MAX_WAIT
// BEHAVIOUR
//  Reset: all outputs 0 (in_ready=0 while rst_n low); state=RUN; drain counter=0.
//  Decode (opcode exact match; all other bits 0):
//   LOAD    0000011: MemtoReg RegWrite MemRead ALUSrc    | STORE 0100011: MemWrite ALUSrc
//   OP      0110011: RegWrite                            | OP-IMM 0010011: RegWrite ALUSrc
//   BRANCH  1100011: branch                              | JAL 1101111: RegWrite jump
//   JALR    1100111: RegWrite jump Jalr ALUSrc           | LUI 0110111: RegWrite Lui
//   AUIPC   0010111: RegWrite Auipc ALUSrc               | MISC-MEM 0001111: Fence
//   SYSTEM  1110011: RegWrite CSRR                       | other: illegal=1, every control bit 0
//  Handshake: accept = in_valid & in_ready; in_ready = (state==RUN) & (~out_valid | out_ready) & ~flush.
//   Accept loads decoded bundle + in_tag next edge, out_valid=1: latency 1 cycle, throughput 1/cycle.
//   out_valid & ~out_ready: bundle and tag held stable. Consume with no accept: out_valid=0.
//  FSM RUN/DRAIN:
//   RUN->DRAIN when a Fence bundle is accepted; counter cleared.
//   DRAIN: in_ready=0. Counter increments each cycle, saturating at FENCE_MAX_WAIT.
//   DRAIN->RUN when mem_idle=1 and the Fence bundle is consumed (out_valid=0 or out_ready=1 this cycle).
//   Counter == FENCE_MAX_WAIT with mem_idle=0: fence_timeout<=1 (sticky), DRAIN->RUN next cycle.
//  Flush (priority over everything but reset): next edge out_valid=0, state=RUN, counter=0; a simultaneous
//   in_valid is dropped (in_ready=0). fence_timeout is cleared only by reset.
//  Reset mid-operation: immediate return to reset values, no held bundle survives.
//  Illegal opcodes flow through the pipeline normally with illegal=1; the exception decision belongs downstream.
// CONFIGURATION
//  CONTROL_UNIT_MEXT_EN defined:
//   OP with funct7=0000001 gives RegWrite=1, mul_div=1.
//   OP with funct7 not in {0000000, 0100000, 0000001} gives illegal=1.
//  Not defined:
//   mul_div tied 0; funct7 ignored, OP always decodes as plain ALU op.
// TESTING
//  Reset then in_valid=1, instr=0x00000013 (ADDI), out_ready=1 -> next cycle out_valid=1, RegWrite=ALUSrc=1, rest 0
//  Back-to-back LW 0x00002083 / SW 0x00112023 / BEQ 0x00000063, out_ready=1 -> 3 bundles on 3 consecutive cycles, tags in order
//  out_ready=0 for 4 cycles holding JALR 0x000080E7 -> bundle/tag stable, in_ready=0, no drop or duplicate
//  FENCE 0x0000000F, mem_idle=0 for 10 cycles then 1 -> in_ready=0 until mem_idle; next instr accepted the cycle after; FENCE_MAX_WAIT=8 variant -> fence_timeout=1
//  flush pulse with out_valid=1 and in_valid=1 in DRAIN -> next cycle out_valid=0, state RUN, input dropped
//  instr=0x02000033 (MUL) -> with MEXT_EN: mul_div=1, RegWrite=1; without: mul_div=0; opcode 0x7F -> illegal=1

Source files
------------

// File: rtl/control_unit_pipe.sv
// Registered RV32I decode stage with valid/ready output register, flush, and FENCE drain FSM.
// Optional M-extension decode is enabled by defining CONTROL_UNIT_MEXT_EN.
module control_unit_pipe #(
    parameter int INSTR_W        = 32,
    parameter int TAG_W          = 4,
    parameter int FENCE_MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               branch,
    output logic               ALUSrc,
    output logic               jump,
    output logic               Jalr,
    output logic               Lui,
    output logic               Auipc,
    output logic               Fence,
    output logic               CSRR,
    output logic               illegal,
    output logic               mul_div,
    input  logic               flush,
    input  logic               mem_idle,
    output logic               fence_timeout
);
    localparam int CNT_W = $clog2(FENCE_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FENCE_MAX_WAIT);

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic branch;
        logic alu_src;
        logic jump;
        logic jalr;
        logic lui;
        logic auipc;
        logic fence;
        logic csrr;
        logic illegal;
        logic mul_div;
    } ctrl_t;

    typedef enum logic {RUN, DRAIN} state_t;

    ctrl_t            dec, ctrl_q;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_n;
    logic             accept, consumed;
    logic [6:0]       opcode;

    assign opcode = in_instr[6:0];

    always_comb begin
        dec = '0;
        case (opcode)
            7'b0000011: begin dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                              dec.mem_read = 1'b1; dec.alu_src = 1'b1; end
            7'b0100011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
            7'b0110011: begin
`ifdef CONTROL_UNIT_MEXT_EN
                case (in_instr[31:25])
                    7'b0000000, 7'b0100000: dec.reg_write = 1'b1;
                    7'b0000001: begin dec.reg_write = 1'b1; dec.mul_div = 1'b1; end
                    default:    dec.illegal = 1'b1;
                endcase
`else
                dec.reg_write = 1'b1;
`endif
            end
            7'b0010011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
            7'b1100011: dec.branch = 1'b1;
            7'b1101111: begin dec.reg_write = 1'b1; dec.jump = 1'b1; end
            7'b1100111: begin dec.reg_write = 1'b1; dec.jump = 1'b1;
                              dec.jalr = 1'b1; dec.alu_src = 1'b1; end
            7'b0110111: begin dec.reg_write = 1'b1; dec.lui = 1'b1; end
            7'b0010111: begin dec.reg_write = 1'b1; dec.auipc = 1'b1; dec.alu_src = 1'b1; end
            7'b0001111: dec.fence = 1'b1;
            7'b1110011: begin dec.reg_write = 1'b1; dec.csrr = 1'b1; end
            default:    dec.illegal = 1'b1;
        endcase
    end

    assign in_ready = rst_n & (state == RUN) & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign consumed = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_tag   <= in_tag;
            ctrl_q    <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            cnt           <= '0;
            fence_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            fence_timeout <= timeout_n;
        end
    end

    // Drain ends on memory idle with the fence gone, or on timeout regardless of the held bundle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        timeout_n = fence_timeout;
        if (flush) begin
            state_n = RUN;
            cnt_n   = '0;
        end else begin
            case (state)
                RUN: begin
                    cnt_n = '0;
                    if (accept && dec.fence) state_n = DRAIN;
                end
                DRAIN: begin
                    if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
                    if (mem_idle && consumed) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else if (!mem_idle && cnt == CNT_MAX) begin
                        timeout_n = 1'b1;
                        state_n   = RUN;
                        cnt_n     = '0;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemWrite = ctrl_q.mem_write;
    assign MemRead  = ctrl_q.mem_read;
    assign branch   = ctrl_q.branch;
    assign ALUSrc   = ctrl_q.alu_src;
    assign jump     = ctrl_q.jump;
    assign Jalr     = ctrl_q.jalr;
    assign Lui      = ctrl_q.lui;
    assign Auipc    = ctrl_q.auipc;
    assign Fence    = ctrl_q.fence;
    assign CSRR     = ctrl_q.csrr;
    assign illegal  = ctrl_q.illegal;
    assign mul_div  = ctrl_q.mul_div;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: decode table, back-pressure, fence drain/timeout, flush, reset.
module tb_control_unit_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0, mem_idle = 1'b1;
    logic [31:0] in_instr = '0;
    logic [3:0]  in_tag = '0;
    wire         in_ready, out_valid, fence_timeout;
    wire  [3:0]  out_tag;
    wire  [13:0] b;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1, flush8 = 1'b0, mem_idle8 = 1'b0;
    logic [31:0] in_instr8 = '0;
    logic [3:0]  in_tag8 = '0;
    wire         in_ready8, out_valid8, fence_timeout8;
    wire  [3:0]  out_tag8;
    wire  [13:0] b8;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_unit_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .MemtoReg(b[13]), .RegWrite(b[12]), .MemWrite(b[11]),
        .MemRead(b[10]), .branch(b[9]), .ALUSrc(b[8]), .jump(b[7]), .Jalr(b[6]),
        .Lui(b[5]), .Auipc(b[4]), .Fence(b[3]), .CSRR(b[2]), .illegal(b[1]),
        .mul_div(b[0]), .flush(flush), .mem_idle(mem_idle), .fence_timeout(fence_timeout)
    );

    control_unit_pipe #(.FENCE_MAX_WAIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_instr(in_instr8), .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_tag(out_tag8), .MemtoReg(b8[13]), .RegWrite(b8[12]), .MemWrite(b8[11]),
        .MemRead(b8[10]), .branch(b8[9]), .ALUSrc(b8[8]), .jump(b8[7]), .Jalr(b8[6]),
        .Lui(b8[5]), .Auipc(b8[4]), .Fence(b8[3]), .CSRR(b8[2]), .illegal(b8[1]),
        .mul_div(b8[0]), .flush(flush8), .mem_idle(mem_idle8), .fence_timeout(fence_timeout8)
    );

    // Expected bundle order: MemtoReg RegWrite MemWrite MemRead branch ALUSrc jump Jalr Lui Auipc Fence CSRR illegal mul_div
    localparam logic [13:0] E_LOAD  = 14'b11010100000000;
    localparam logic [13:0] E_STORE = 14'b00100100000000;
    localparam logic [13:0] E_OP    = 14'b01000000000000;
    localparam logic [13:0] E_OPIMM = 14'b01000100000000;
    localparam logic [13:0] E_BR    = 14'b00001000000000;
    localparam logic [13:0] E_JAL   = 14'b01000010000000;
    localparam logic [13:0] E_JALR  = 14'b01000111000000;
    localparam logic [13:0] E_LUI   = 14'b01000000100000;
    localparam logic [13:0] E_AUIPC = 14'b01000100010000;
    localparam logic [13:0] E_FENCE = 14'b00000000001000;
    localparam logic [13:0] E_SYS   = 14'b01000000000100;
    localparam logic [13:0] E_ILL   = 14'b00000000000010;
`ifdef CONTROL_UNIT_MEXT_EN
    localparam logic [13:0] E_MUL   = 14'b01000000000001;
    localparam logic [13:0] E_BADF7 = E_ILL;
`else
    localparam logic [13:0] E_MUL   = E_OP;
    localparam logic [13:0] E_BADF7 = E_OP;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{32'h00000013, E_OPIMM};
        vecs[1]  = '{32'h00002083, E_LOAD};
        vecs[2]  = '{32'h00112023, E_STORE};
        vecs[3]  = '{32'h00000063, E_BR};
        vecs[4]  = '{32'h0000006F, E_JAL};
        vecs[5]  = '{32'h000080E7, E_JALR};
        vecs[6]  = '{32'h000000B7, E_LUI};
        vecs[7]  = '{32'h00000097, E_AUIPC};
        vecs[8]  = '{32'h00000073, E_SYS};
        vecs[9]  = '{32'h00000033, E_OP};
        vecs[10] = '{32'h40000033, E_OP};
        vecs[11] = '{32'h02000033, E_MUL};
        vecs[12] = '{32'h0000007F, E_ILL};
        vecs[13] = '{32'hFE000033, E_BADF7};

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_bundle", {18'b0, b}, 32'd0);
        chk("rst_timeout", {31'b0, fence_timeout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Decode table streamed back-to-back
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 4'(i);
            chk($sformatf("in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("bundle_%0d", i), {18'b0, b}, {18'b0, vecs[i].exp});
            chk($sformatf("tag_%0d", i), {28'b0, out_tag}, {28'b0, 4'(i)});
            chk($sformatf("out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure holding JALR
        in_valid = 1'b1; in_instr = 32'h000080E7; in_tag = 4'd5; out_ready = 1'b0;
        tick();
        in_instr = 32'h00000013; in_tag = 4'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_bundle", {18'b0, b}, {18'b0, E_JALR});
            chk("stall_tag", {28'b0, out_tag}, 32'd5);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("release_tag", {28'b0, out_tag}, 32'd9);
        chk("release_bundle", {18'b0, b}, {18'b0, E_OPIMM});
        tick();
        chk("no_dup", {31'b0, out_valid}, 32'd0);

        // FENCE drain with memory busy for 10 cycles
        mem_idle = 1'b0; in_valid = 1'b1; in_instr = 32'h0000000F; in_tag = 4'd3;
        tick();
        chk("fence_bundle", {18'b0, b}, {18'b0, E_FENCE});
        in_instr = 32'h00000013; in_tag = 4'd4;
        for (int i = 0; i < 10; i++) begin
            chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        mem_idle = 1'b1;
        #1;
        chk("idle_edge_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("post_drain_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("post_drain_tag", {28'b0, out_tag}, 32'd4);
        chk("post_drain_valid", {31'b0, out_valid}, 32'd1);
        tick();

        // Flush while holding a fence in DRAIN with a pending input
        out_ready = 1'b0; mem_idle = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000000F; in_tag = 4'd2;
        tick();
        in_instr = 32'h00000013; in_tag = 4'd6; flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_run", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1; mem_idle = 1'b1;
        tick();
        chk("flush_dropped", {31'b0, out_valid}, 32'd0);
        chk("no_timeout_main", {31'b0, fence_timeout}, 32'd0);

        // Timeout on the FENCE_MAX_WAIT=8 instance
        in_valid8 = 1'b1; in_instr8 = 32'h0000000F; in_tag8 = 4'd7;
        tick();
        in_valid8 = 1'b0;
        #1;
        chk("to_drain_in_ready", {31'b0, in_ready8}, 32'd0);
        n = 0;
        while (!fence_timeout8 && n < 30) begin
            tick();
            n++;
        end
        chk("timeout_set", {31'b0, fence_timeout8}, 32'd1);
        chk("timeout_cycles", n, 32'd9);
        chk("timeout_run", {31'b0, in_ready8}, 32'd1);
        tick();
        chk("timeout_sticky", {31'b0, fence_timeout8}, 32'd1);

        // Reset mid-operation with a held bundle
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00002083; in_tag = 4'd1;
        tick();
        chk("held_before_rst", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_bundle", {18'b0, b}, 32'd0);
        chk("midrst_timeout", {31'b0, fence_timeout8}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
